// File: rtl/pll_lock_sequencer.sv
// PLL lock sequencer: pulses the PLL reset, qualifies the PLL locked flag over a
// programmable stable window, then releases a design-wide run enable. Timeouts
// and lock loss trigger a retry. After a bounded number of failed attempts the
// block parks in a sticky failure state until reset or restart.
module pll_lock_sequencer #(
  parameter int unsigned RST_CYCLES    = 64,
  parameter int unsigned LOCK_TIMEOUT  = 100000,
  parameter int unsigned STABLE_CYCLES = 4096,
  parameter int unsigned LOSS_FILTER   = 4,
  parameter int unsigned MAX_RETRY     = 7,
  parameter int unsigned CNT_W         = 20
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       pll_locked,
  input  logic       restart,
  output logic       pll_rst,
  output logic       run,
  output logic       fail,
  output logic [3:0] retry_cnt,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_t;

  // Largest count the shared counter can represent, plus one.
  localparam longint unsigned CNT_SPAN = 64'd1 << CNT_W;

  // Terminal counts, truncated to the counter width.
  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOSS_LAST   = CNT_W'(LOSS_FILTER - 1);
  localparam logic [3:0]       RETRY_LIMIT = 4'(MAX_RETRY);

  // Every window length must be non-zero.
  if (RST_CYCLES < 1 || LOCK_TIMEOUT < 1 || STABLE_CYCLES < 1 || LOSS_FILTER < 1)
  begin : g_bad_window
    $error("pll_lock_sequencer: all cycle windows must be at least 1");
  end

  // The shared counter and the loss counter must reach every terminal count.
  if (CNT_W < 1 || CNT_W > 32 ||
      64'(RST_CYCLES) > CNT_SPAN || 64'(LOCK_TIMEOUT) > CNT_SPAN ||
      64'(STABLE_CYCLES) > CNT_SPAN || 64'(LOSS_FILTER) > CNT_SPAN)
  begin : g_bad_cnt_w
    $error("pll_lock_sequencer: CNT_W too small for the configured windows");
  end

  // The retry counter is four bits wide, so the limit has to fit in it.
  if (MAX_RETRY > 15) begin : g_bad_retry
    $error("pll_lock_sequencer: MAX_RETRY must not exceed 15");
  end

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] loss_q;
  logic [3:0]       retry_q;
  logic             pllRst_q;
  logic             run_q;
  logic             fail_q;
  logic             lkMeta_q;
  logic             lkSync_q;
  logic [3:0]       retryInc_d;
  logic             lk;

  // Two-flop synchronizer for the asynchronous locked flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lkMeta_q <= 1'b0;
      lkSync_q <= 1'b0;
    end else begin
      lkMeta_q <= pll_locked;
      lkSync_q <= lkMeta_q;
    end
  end

  assign lk = lkSync_q;

  // Saturating increment so the retry count sticks at 15 instead of wrapping.
  always_comb begin
    retryInc_d = retry_q;
    if (retry_q != 4'hF) begin
      retryInc_d = retry_q + 4'd1;
    end
  end

  // Sequencer FSM; pll_rst, run and fail are registered alongside the state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_PLL_RST;
      cnt_q    <= '0;
      loss_q   <= '0;
      retry_q  <= 4'd0;
      pllRst_q <= 1'b1;
      run_q    <= 1'b0;
      fail_q   <= 1'b0;
    end else if (restart) begin
      state_q  <= ST_PLL_RST;
      cnt_q    <= '0;
      loss_q   <= '0;
      retry_q  <= 4'd0;
      pllRst_q <= 1'b1;
      run_q    <= 1'b0;
      fail_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_PLL_RST: begin
          if (cnt_q == RST_LAST) begin
            state_q  <= ST_WAIT_LOCK;
            cnt_q    <= '0;
            pllRst_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        ST_WAIT_LOCK: begin
          if (lk) begin
            state_q <= ST_STABLE;
            cnt_q   <= '0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            cnt_q    <= '0;
            pllRst_q <= 1'b1;
            if (retry_q == RETRY_LIMIT) begin
              state_q <= ST_FAIL;
              fail_q  <= 1'b1;
            end else begin
              state_q <= ST_PLL_RST;
              retry_q <= retryInc_d;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        ST_STABLE: begin
          if (!lk) begin
            state_q <= ST_WAIT_LOCK;
            cnt_q   <= '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            loss_q  <= '0;
            run_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        ST_RUN: begin
          if (lk) begin
            loss_q <= '0;
          end else if (loss_q == LOSS_LAST) begin
            state_q  <= ST_PLL_RST;
            cnt_q    <= '0;
            loss_q   <= '0;
            run_q    <= 1'b0;
            pllRst_q <= 1'b1;
            retry_q  <= retryInc_d;
          end else begin
            loss_q <= loss_q + CNT_W'(1);
          end
        end

        ST_FAIL: begin
          pllRst_q <= 1'b1;
          run_q    <= 1'b0;
          fail_q   <= 1'b1;
        end

        default: begin
          state_q  <= ST_PLL_RST;
          cnt_q    <= '0;
          loss_q   <= '0;
          pllRst_q <= 1'b1;
          run_q    <= 1'b0;
          fail_q   <= 1'b0;
        end
      endcase
    end
  end

  assign pll_rst   = pllRst_q;
  assign run       = run_q;
  assign fail      = fail_q;
  assign retry_cnt = retry_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Testbench for pll_lock_sequencer: directed vector table plus randomized lock
// behaviour, both checked cycle by cycle against a behavioural phase model.
module tb_pll_lock_sequencer;

  localparam int P_RST    = 4;
  localparam int P_TO     = 20;
  localparam int P_STABLE = 8;
  localparam int P_LOSS   = 3;
  localparam int P_MAX    = 2;

  logic       clk = 1'b0;
  logic       rstn;
  logic       pllLocked;
  logic       restartIn;
  logic       pllRst;
  logic       runO;
  logic       failO;
  logic [3:0] retryCnt;
  logic [2:0] stateO;

  int testsRun    = 0;
  int testsFailed = 0;

  // Behavioural model: current phase, edges spent in it, and recent pin samples.
  int mState;
  int mElapsed;
  int mLoss;
  int mRetry;
  bit histQ[$];

  typedef struct {
    bit rs;
    bit lock;
    int n;
    int st;
    bit prst;
    bit run;
    bit fail;
    int retry;
  } vec_t;

  vec_t vecs[$];

  // Free-running 100 MHz-in-sim reference clock.
  always #5 clk = ~clk;

  pll_lock_sequencer #(
    .RST_CYCLES   (P_RST),
    .LOCK_TIMEOUT (P_TO),
    .STABLE_CYCLES(P_STABLE),
    .LOSS_FILTER  (P_LOSS),
    .MAX_RETRY    (P_MAX),
    .CNT_W        (8)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .pll_locked(pllLocked),
    .restart   (restartIn),
    .pll_rst   (pllRst),
    .run       (runO),
    .fail      (failO),
    .retry_cnt (retryCnt),
    .state_o   (stateO)
  );

  function automatic void modelReset();
    mState   = 0;
    mElapsed = 0;
    mLoss    = 0;
    mRetry   = 0;
    histQ.delete();
  endfunction

  function automatic void enterPhase(int s);
    mState   = s;
    mElapsed = 0;
    mLoss    = 0;
  endfunction

  function automatic int satInc(int v);
    return (v < 15) ? v + 1 : 15;
  endfunction

  // One rising edge: the decision sees the pin as sampled two edges earlier.
  function automatic void modelStep(bit pin, bit rs);
    bit lk;
    lk = (histQ.size() >= 2) ? histQ[1] : 1'b0;
    histQ.push_front(pin);
    if (histQ.size() > 2) void'(histQ.pop_back());
    if (rs) begin
      enterPhase(0);
      mRetry = 0;
      return;
    end
    case (mState)
      0: begin
        mElapsed++;
        if (mElapsed == P_RST) enterPhase(1);
      end
      1: begin
        if (lk) enterPhase(2);
        else begin
          mElapsed++;
          if (mElapsed == P_TO) begin
            if (mRetry == P_MAX) enterPhase(4);
            else begin
              mRetry = satInc(mRetry);
              enterPhase(0);
            end
          end
        end
      end
      2: begin
        if (!lk) enterPhase(1);
        else begin
          mElapsed++;
          if (mElapsed == P_STABLE) enterPhase(3);
        end
      end
      3: begin
        if (lk) mLoss = 0;
        else begin
          mLoss++;
          if (mLoss == P_LOSS) begin
            mRetry = satInc(mRetry);
            enterPhase(0);
          end
        end
      end
      default: ;
    endcase
  endfunction

  task automatic checkOutput(string name, int st, bit prst, bit run, bit fl, int retry);
    testsRun++;
    if (stateO !== st[2:0] || pllRst !== prst || runO !== run ||
        failO !== fl || retryCnt !== retry[3:0]) begin
      testsFailed++;
      $display("[TB] FAIL %s: got state=%0d pll_rst=%b run=%b fail=%b retry=%0d, expected state=%0d pll_rst=%b run=%b fail=%b retry=%0d",
               name, stateO, pllRst, runO, failO, retryCnt, st, prst, run, fl, retry);
    end
  endtask

  // Advance one clock, step the model, and compare at the falling edge.
  task automatic tick();
    @(posedge clk);
    if (!rstn) modelReset();
    else modelStep(pllLocked, restartIn);
    @(negedge clk);
    checkOutput("cycle", mState, (mState == 0) || (mState == 4), mState == 3,
                mState == 4, mRetry);
  endtask

  task automatic applyStimulus(bit rs, bit lock, int n);
    for (int i = 0; i < n; i++) begin
      restartIn = rs && (i == 0);
      pllLocked = lock;
      tick();
    end
    restartIn = 1'b0;
  endtask

  function automatic void addVec(bit rs, bit lock, int n, int st, bit prst,
                                 bit run, bit fl, int retry);
    vec_t v;
    v.rs = rs; v.lock = lock; v.n = n; v.st = st;
    v.prst = prst; v.run = run; v.fail = fl; v.retry = retry;
    vecs.push_back(v);
  endfunction

  initial begin
    bit lockLvl;
    rstn      = 1'b1;
    pllLocked = 1'b0;
    restartIn = 1'b0;
    modelReset();
    #1 rstn = 1'b0;

    // Normal bring-up: lock appears five cycles after pll_rst falls.
    addVec(0, 0, 3,  0, 1, 0, 0, 0);
    addVec(0, 0, 1,  1, 0, 0, 0, 0);
    addVec(0, 0, 4,  1, 0, 0, 0, 0);
    addVec(0, 1, 10, 2, 0, 0, 0, 0);
    addVec(0, 1, 1,  3, 0, 1, 0, 0);
    // Glitch of two cycles is filtered, three cycles drops run.
    addVec(0, 0, 2,  3, 0, 1, 0, 0);
    addVec(0, 1, 4,  3, 0, 1, 0, 0);
    addVec(0, 0, 3,  3, 0, 1, 0, 0);
    addVec(0, 0, 1,  3, 0, 1, 0, 0);
    addVec(0, 0, 1,  0, 1, 0, 0, 1);
    // Timeout retries ending in the sticky failure state.
    addVec(1, 0, 1,  0, 1, 0, 0, 0);
    addVec(0, 0, 4,  1, 0, 0, 0, 0);
    addVec(0, 0, 19, 1, 0, 0, 0, 0);
    addVec(0, 0, 1,  0, 1, 0, 0, 1);
    addVec(0, 0, 4,  1, 0, 0, 0, 1);
    addVec(0, 0, 20, 0, 1, 0, 0, 2);
    addVec(0, 0, 4,  1, 0, 0, 0, 2);
    addVec(0, 0, 19, 1, 0, 0, 0, 2);
    addVec(0, 0, 1,  4, 1, 0, 1, 2);
    addVec(0, 0, 30, 4, 1, 0, 1, 2);
    // Restart out of the failure state, then a clean bring-up.
    addVec(1, 0, 1,  0, 1, 0, 0, 0);
    addVec(0, 1, 4,  1, 0, 0, 0, 0);
    addVec(0, 1, 1,  2, 0, 0, 0, 0);
    addVec(0, 1, 7,  2, 0, 0, 0, 0);
    addVec(0, 1, 1,  3, 0, 1, 0, 0);
    // Restart landing on the timeout cycle wins over the retry.
    addVec(1, 0, 1,  0, 1, 0, 0, 0);
    addVec(0, 0, 4,  1, 0, 0, 0, 0);
    addVec(0, 0, 19, 1, 0, 0, 0, 0);
    addVec(1, 0, 1,  0, 1, 0, 0, 0);
    addVec(0, 1, 4,  1, 0, 0, 0, 0);
    addVec(0, 1, 1,  2, 0, 0, 0, 0);
    addVec(0, 1, 8,  3, 0, 1, 0, 0);
    // Unstable lock: brief drop during the stable window, no retry counted.
    addVec(1, 0, 1,  0, 1, 0, 0, 0);
    addVec(0, 0, 4,  1, 0, 0, 0, 0);
    addVec(0, 1, 5,  2, 0, 0, 0, 0);
    addVec(0, 0, 1,  2, 0, 0, 0, 0);
    addVec(0, 1, 2,  1, 0, 0, 0, 0);
    addVec(0, 1, 1,  2, 0, 0, 0, 0);
    addVec(0, 1, 7,  2, 0, 0, 0, 0);
    addVec(0, 1, 1,  3, 0, 1, 0, 0);

    applyStimulus(0, 0, 2);
    checkOutput("reset", 0, 1, 0, 0, 0);
    rstn = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rs, vecs[i].lock, vecs[i].n);
      checkOutput($sformatf("vec%0d", i), vecs[i].st, vecs[i].prst, vecs[i].run,
                  vecs[i].fail, vecs[i].retry);
    end

    // Asynchronous reset in the middle of the stable window.
    applyStimulus(1, 0, 1);
    applyStimulus(0, 1, 4);
    applyStimulus(0, 1, 1);
    applyStimulus(0, 1, 3);
    checkOutput("pre_reset_stable", 2, 0, 0, 0, 0);
    #2 rstn = 1'b0;
    #1;
    checkOutput("async_reset", 0, 1, 0, 0, 0);
    testsRun++;
    if (dut.lkMeta_q !== 1'b0 || dut.lkSync_q !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL sync_clear: got meta=%b sync=%b, expected 0 0",
               dut.lkMeta_q, dut.lkSync_q);
    end
    modelReset();
    applyStimulus(0, 1, 2);
    checkOutput("held_reset", 0, 1, 0, 0, 0);
    rstn = 1'b1;
    applyStimulus(0, 1, P_RST);
    checkOutput("post_reset_wait", 1, 0, 0, 0, 0);

    // Randomized lock behaviour with occasional glitches and restarts.
    lockLvl = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 39) == 0) lockLvl = ~lockLvl;
      pllLocked = (lockLvl && $urandom_range(0, 49) == 0) ? 1'b0 : lockLvl;
      restartIn = ($urandom_range(0, 149) == 0);
      tick();
    end
    restartIn = 1'b0;

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
- Sequences reset and lock qualification for the board clock-generator PLL (50 MHz reference in, 250/25/100 MHz out).
- Runs on the free-running reference clock. Drives the PLL reset and filters/synchronizes the asynchronous PLL locked flag.
- Releases a design-wide run enable only after lock has been stable for a programmable time.
- Retries on lock timeout or lock loss, and flags a hard failure after a bounded number of retries.

Parameters:
- RST_CYCLES, 64, cycles pll_rst is held high per attempt (≥1)
- LOCK_TIMEOUT, 100000, cycles allowed in WAIT_LOCK before the attempt is declared failed
- STABLE_CYCLES, 4096, consecutive synchronized-locked cycles required before run asserts
- LOSS_FILTER, 4, consecutive synchronized-unlocked cycles in RUN that count as lock loss
- MAX_RETRY, 7, failed attempts tolerated before FAIL (0 = fail on first timeout)
- CNT_W, 20, width of the shared cycle counter (must hold max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES))

Ports:
- clk  in  1  reference clock, 50 MHz, free-running
- rstn  in  1  asynchronous active-low reset
- pll_locked  in  1  PLL locked flag, asynchronous to clk
- restart  in  1  single-cycle request to restart the sequence from PLL_RST
- pll_rst  out  1  PLL reset, active high
- run  out  1  high while lock is qualified; downstream resets release on this
- fail  out  1  sticky hard-failure flag
- retry_cnt  out  4  number of failed attempts since reset/restart (saturating)
- state_o  out  3  current state encoding, for debug

Behaviour:
- Reset is asynchronous and active-low, on rstn; all logic is clocked on the rising edge of clk.
- Reset values: pll_rst=1, run=0, fail=0, retry_cnt=0, state=PLL_RST, counter=0, synchronizer=0.
- pll_locked passes through a 2-flop synchronizer; the synchronized value is lk. All decisions use lk only, so lock-related decisions lag the pin by 2 cycles.
- States: PLL_RST=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4.
- PLL_RST:
  - pll_rst=1, counter increments.
  - When counter==RST_CYCLES-1: go to WAIT_LOCK, counter cleared.
- WAIT_LOCK:
  - pll_rst=0.
  - If lk=1: go to STABLE, counter cleared.
  - Else if counter==LOCK_TIMEOUT-1: attempt failed.
    - If retry_cnt==MAX_RETRY: go to FAIL.
    - Otherwise retry_cnt++ and go to PLL_RST.
  - The lk check has priority over the timeout on the same cycle.
- STABLE:
  - pll_rst=0.
  - If lk=0: return to WAIT_LOCK with the counter cleared. This does not count as a retry.
  - When counter==STABLE_CYCLES-1 with lk=1: go to RUN.
- RUN:
  - run=1. It is registered, so it rises the cycle the state becomes RUN.
  - A loss counter counts consecutive lk=0 cycles and clears on any lk=1.
  - When it reaches LOSS_FILTER: run drops the same cycle, retry_cnt++ (saturating at 15), go to PLL_RST.
  - Glitches shorter than LOSS_FILTER do not drop run.
- FAIL:
  - pll_rst=1, run=0, fail=1.
  - Held until rstn or restart.
- restart:
  - Accepted in any state.
  - Next cycle: state=PLL_RST, counter=0, run=0, fail=0, retry_cnt=0.
  - restart overrides every same-cycle transition.
- run is 1 only in RUN. pll_rst is 1 only in PLL_RST and FAIL.
- retry_cnt saturates at 15 and never wraps.
- Counter width: comparisons are against parameters truncated to CNT_W. The implementation adds an elaboration check that CNT_W is sufficient.
- Reset mid-operation: outputs return to their reset values immediately and asynchronously, and the sequence restarts at PLL_RST.

Test Plan:
Parameters for all scenarios: RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, LOSS_FILTER=3, MAX_RETRY=2.
1. Normal bring-up: release rstn; raise pll_locked 5 cycles after pll_rst falls.
   -> pll_rst high for exactly 4 cycles; run rises 2+8 cycles after pll_locked rises; retry_cnt=0.
2. Timeout retry: pll_locked held 0.
   -> pll_rst pulses 3 times (4 cycles each, 20 cycles apart); retry_cnt 1 then 2; then FAIL with fail=1, pll_rst=1, run=0 permanently.
3. Unstable lock: lock high for 5 cycles, low for 1, then high.
   -> return to WAIT_LOCK, no retry increment; run rises 10 cycles after the final rise.
4. RUN glitch filter: in RUN, drop pll_locked for 2 cycles -> run stays 1. Drop it for 3 cycles -> run falls, retry_cnt=1, pll_rst rises next cycle.
5. restart from FAIL, and restart on a timeout cycle:
   -> state=PLL_RST next cycle; fail=0; retry_cnt=0; normal bring-up follows.
6. Async reset in STABLE: assert rstn low mid-count.
   -> pll_rst=1 and state_o=0 before the next clk edge; the synchronizer is cleared.
